// File: rtl/twotrafficlights_pkg.sv
// rtl/twotrafficlights_pkg.sv - shared types and helpers for the two-light monitor
// Contents:
//   light_t      3-bit {red,amber,green} light encoding plus the four legal aspects
//   err_code_t   violation codes reported by the monitor
//   chk_state_t  per-light checker state
//   is_legal     1 when a sample is one of the four legal aspects
//   next_aspect  the aspect that legally follows a given aspect
//   to_state     legal aspect -> checker state
//   state_aspect checker state -> aspect it remembers
package twotrafficlights_pkg;

   typedef logic [2:0] light_t;

   localparam light_t RED     = 3'b100;
   localparam light_t RED_AMB = 3'b110;
   localparam light_t GREEN   = 3'b001;
   localparam light_t AMBER   = 3'b010;

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      ILLEGAL   = 3'd1,
      CONFLICT  = 3'd2,
      BAD_TRANS = 3'd3,
      STUCK     = 3'd4
   } err_code_t;

   typedef enum logic [2:0] {
      ST_UNSEEN  = 3'd0,
      ST_RED     = 3'd1,
      ST_RED_AMB = 3'd2,
      ST_GREEN   = 3'd3,
      ST_AMBER   = 3'd4
   } chk_state_t;

   function automatic logic is_legal(input light_t l);
      return (l == RED) || (l == RED_AMB) || (l == GREEN) || (l == AMBER);
   endfunction

   function automatic light_t next_aspect(input light_t l);
      light_t n;
      case (l)
         RED:     n = RED_AMB;
         RED_AMB: n = GREEN;
         GREEN:   n = AMBER;
         AMBER:   n = RED;
         default: n = RED;
      endcase
      return n;
   endfunction

   function automatic chk_state_t to_state(input light_t l);
      chk_state_t s;
      case (l)
         RED:     s = ST_RED;
         RED_AMB: s = ST_RED_AMB;
         GREEN:   s = ST_GREEN;
         AMBER:   s = ST_AMBER;
         default: s = ST_UNSEEN;
      endcase
      return s;
   endfunction

   // ST_UNSEEN maps to an encoding that never matches a legal sample.
   function automatic light_t state_aspect(input chk_state_t s);
      light_t l;
      case (s)
         ST_RED:     l = RED;
         ST_RED_AMB: l = RED_AMB;
         ST_GREEN:   l = GREEN;
         ST_AMBER:   l = AMBER;
         default:    l = 3'b000;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/twotrafficlights_monitor_light_seq_checker.sv
// rtl/twotrafficlights_monitor_light_seq_checker.sv - sequence and dwell checker for one light
// Ports:
//   clk        clock, state on rising edge
//   rst        asynchronous active-high reset, returns checker to ST_UNSEEN
//   light      current {red,amber,green} sample
//   is_red     current sample is exactly RED
//   illegal    current sample is not a legal aspect
//   bad_trans  legal sample that is neither a hold nor the next aspect
//   stuck      this sample extends a hold to MAX_DWELL+1 samples or beyond
//   completed  this sample closes an AMBER->RED transition
// Violation and completion flags are combinational views of the current
// sample; the top registers them on the same edge the sample is taken.
module light_seq_checker
   import twotrafficlights_pkg::*;
#(
   parameter int MAX_DWELL = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] light,
   output logic       is_red,
   output logic       illegal,
   output logic       bad_trans,
   output logic       stuck,
   output logic       completed
);

   localparam int DW_W = $clog2(MAX_DWELL + 1);
   localparam logic [DW_W-1:0] DW_MAX = DW_W'(MAX_DWELL);
   localparam logic [DW_W-1:0] DW_LIM = DW_W'(MAX_DWELL + 1);
   localparam logic [DW_W-1:0] DW_ONE = DW_W'(1);

   chk_state_t      state;
   logic [DW_W-1:0] dwell;

   light_t cur;
   logic   seen;
   logic   legal;
   logic   same;
   logic   advance;

   assign cur     = state_aspect(state);
   assign seen    = (state != ST_UNSEEN);
   assign legal   = is_legal(light);
   assign same    = seen && (light == cur);
   assign advance = seen && (light == next_aspect(cur));

   assign is_red    = (light == RED);
   assign illegal   = !legal;
   assign bad_trans = legal && seen && !same && !advance;
   // dwell already counts MAX_DWELL samples, so one more hold is one too many
   assign stuck     = legal && same && (dwell >= DW_MAX);
   assign completed = legal && seen && (cur == AMBER) && (light == RED);

   // An illegal sample leaves state and dwell untouched. A bad transition
   // resynchronises to the new aspect so later checks stay meaningful.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_UNSEEN;
         dwell <= '0;
      end else if (legal) begin
         state <= to_state(light);
         if (same) begin
            if (dwell != DW_LIM)
               dwell <= dwell + DW_ONE;
         end else begin
            dwell <= DW_ONE;
         end
      end
   end

endmodule

// File: rtl/twotrafficlights_monitor.sv
// rtl/twotrafficlights_monitor.sv - passive checker on the two-light controller outputs
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   lightsA      light A sample {red,amber,green}
//   lightsB      light B sample, same encoding
//   err          sticky, a violation has been captured
//   err_code     code of the first violation (err_code_t)
//   err_light    0 = light A, 1 = light B (0 for CONFLICT)
//   err_time     cycle_count value when the violation was sampled
//   cycle_count  samples since reset, saturating
//   phases_done  completed red->red cycles of A plus B, saturating
module twotrafficlights_monitor
   import twotrafficlights_pkg::*;
#(
   parameter int MAX_DWELL = 16,
   parameter int CNT_W     = 16,
   parameter int PH_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       lightsA,
   input  logic [2:0]       lightsB,
   output logic             err,
   output logic [2:0]       err_code,
   output logic             err_light,
   output logic [CNT_W-1:0] err_time,
   output logic [CNT_W-1:0] cycle_count,
   output logic [PH_W-1:0]  phases_done
);

   logic a_red, a_ill, a_bad, a_stuck, a_cmp;
   logic b_red, b_ill, b_bad, b_stuck, b_cmp;
   logic conflict;

   light_seq_checker #(.MAX_DWELL(MAX_DWELL)) u_chk_a (
      .clk       (clk),
      .rst       (rst),
      .light     (lightsA),
      .is_red    (a_red),
      .illegal   (a_ill),
      .bad_trans (a_bad),
      .stuck     (a_stuck),
      .completed (a_cmp)
   );

   light_seq_checker #(.MAX_DWELL(MAX_DWELL)) u_chk_b (
      .clk       (clk),
      .rst       (rst),
      .light     (lightsB),
      .is_red    (b_red),
      .illegal   (b_ill),
      .bad_trans (b_bad),
      .stuck     (b_stuck),
      .completed (b_cmp)
   );

   // At least one light must show plain RED on every sample.
   assign conflict = !a_red && !b_red;

   logic      v_hit;
   err_code_t v_code;
   logic      v_light;

   // Fixed priority: ILLEGAL > CONFLICT > BAD_TRANS > STUCK, A before B.
   always_comb begin
      v_hit   = 1'b1;
      v_code  = NONE;
      v_light = 1'b0;
      if (a_ill) begin
         v_code = ILLEGAL;
      end else if (b_ill) begin
         v_code  = ILLEGAL;
         v_light = 1'b1;
      end else if (conflict) begin
         v_code = CONFLICT;
      end else if (a_bad) begin
         v_code = BAD_TRANS;
      end else if (b_bad) begin
         v_code  = BAD_TRANS;
         v_light = 1'b1;
      end else if (a_stuck) begin
         v_code = STUCK;
      end else if (b_stuck) begin
         v_code  = STUCK;
         v_light = 1'b1;
      end else begin
         v_hit = 1'b0;
      end
   end

   // One extra bit catches the carry when adding up to two completions.
   logic [PH_W:0] ph_sum;
   assign ph_sum = {1'b0, phases_done} + (PH_W+1)'(a_cmp) + (PH_W+1)'(b_cmp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err         <= 1'b0;
         err_code    <= NONE;
         err_light   <= 1'b0;
         err_time    <= '0;
         cycle_count <= '0;
         phases_done <= '0;
      end else begin
         if (cycle_count != {CNT_W{1'b1}})
            cycle_count <= cycle_count + CNT_W'(1);

         if (ph_sum[PH_W])
            phases_done <= {PH_W{1'b1}};
         else
            phases_done <= ph_sum[PH_W-1:0];

         // First violation wins; capture fields are frozen afterwards.
         if (!err && v_hit) begin
            err       <= 1'b1;
            err_code  <= v_code;
            err_light <= v_light;
            err_time  <= cycle_count;
         end
      end
   end

endmodule

// File: tb/tb_twotrafficlights_monitor.sv
// tb/tb_twotrafficlights_monitor.sv - self-checking bench for twotrafficlights_monitor
module tb_twotrafficlights_monitor;
   import twotrafficlights_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  lightsA = 3'b100;
   logic [2:0]  lightsB = 3'b100;
   logic        err;
   logic [2:0]  err_code;
   logic        err_light;
   logic [15:0] err_time;
   logic [15:0] cycle_count;
   logic [7:0]  phases_done;

   twotrafficlights_monitor #(.MAX_DWELL(16), .CNT_W(16), .PH_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .lightsA     (lightsA),
      .lightsB     (lightsB),
      .err         (err),
      .err_code    (err_code),
      .err_light   (err_light),
      .err_time    (err_time),
      .cycle_count (cycle_count),
      .phases_done (phases_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [2:0]  a;
      logic [2:0]  b;
      logic        e;
      logic [2:0]  code;
      logic        lt;
      logic [15:0] t;
      logic [7:0]  ph;
   } vec_t;

   typedef struct {
      logic        e;
      logic [2:0]  code;
      logic        lt;
      logic [15:0] t;
      logic [15:0] cc;
      logic [7:0]  ph;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   tb_cnt = 0;
   int   step_id = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s step %0d: got %0d expected %0d", nm, step_id, act, expv);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [2:0] a, input logic [2:0] b,
                               input logic e, input logic [2:0] code, input logic lt,
                               input logic [15:0] t, input logic [7:0] ph);
      vec_t v;
      v.r = r; v.a = a; v.b = b; v.e = e; v.code = code; v.lt = lt; v.t = t; v.ph = ph;
      return v;
   endfunction

   // Drive one sample, queue its expected outputs, pop and compare after the edge.
   task automatic apply(input vec_t v);
      exp_t x;
      exp_t y;
      if (v.r) tb_cnt = 0;
      else     tb_cnt = tb_cnt + 1;
      x.e = v.e; x.code = v.code; x.lt = v.lt; x.t = v.t; x.ph = v.ph;
      x.cc = 16'(tb_cnt);
      sb.push_back(x);
      rst     = v.r;
      lightsA = v.a;
      lightsB = v.b;
      @(posedge clk);
      #1;
      step_id++;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         y = sb.pop_front();
         chk("err",         32'(err),         32'(y.e));
         chk("err_code",    32'(err_code),    32'(y.code));
         chk("err_light",   32'(err_light),   32'(y.lt));
         chk("err_time",    32'(err_time),    32'(y.t));
         chk("cycle_count", 32'(cycle_count), 32'(y.cc));
         chk("phases_done", 32'(phases_done), 32'(y.ph));
      end
      rst = 1'b0;
   endtask

   task automatic drive_only(input logic [2:0] a, input logic [2:0] b);
      lightsA = a;
      lightsB = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Full legal A cycle, 3 samples per aspect, B held RED
      tbl.push_back(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 3'b110, 3'b100, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 1));
      // CONFLICT at sample 5 (B also bad-transitions, CONFLICT wins)
      tbl.push_back(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b110, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b110, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b001, 3'b001, 1, 3'd2, 0, 4, 0));
      tbl.push_back(mk(0, 3'b001, 3'b100, 1, 3'd2, 0, 4, 0));
      // BAD_TRANS on A at sample 7, later CONFLICT ignored
      tbl.push_back(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b001, 3'b100, 1, 3'd3, 0, 6, 0));
      tbl.push_back(mk(0, 3'b001, 3'b001, 1, 3'd3, 0, 6, 0));
      // B illegal beats A bad transition and the conflict
      tbl.push_back(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b001, 3'b111, 1, 3'd1, 1, 2, 0));
      // Both illegal on the very first sample: A wins
      tbl.push_back(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3'b000, 3'b111, 1, 3'd1, 0, 0, 0));

      foreach (tbl[i]) apply(tbl[i]);

      // STUCK: 17 RED samples, both lights stuck together, A wins
      apply(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      for (int s = 0; s < 17; s++) begin
         if (s == 16) apply(mk(0, 3'b100, 3'b100, 1, 3'd4, 0, 16, 0));
         else         apply(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      end
      apply(mk(0, 3'b110, 3'b100, 1, 3'd4, 0, 16, 0));

      // Asynchronous reset mid-run after an error
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_err",         32'(err),         32'd0);
      chk("async_rst_err_code",    32'(err_code),    32'd0);
      chk("async_rst_err_time",    32'(err_time),    32'd0);
      chk("async_rst_cycle_count", 32'(cycle_count), 32'd0);
      @(posedge clk);
      #1;
      apply(mk(1, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      // First sample after release is GREEN: accepted without transition check
      apply(mk(0, 3'b001, 3'b100, 0, 0, 0, 0, 0));
      apply(mk(0, 3'b010, 3'b100, 0, 0, 0, 0, 0));
      apply(mk(0, 3'b100, 3'b100, 0, 0, 0, 0, 1));

      // phases_done saturation: 260 completions of A, B stuck at sample 16
      apply(mk(1, 3'b100, 3'b100, 0, 0, 0, 0, 0));
      for (int k = 0; k < 260; k++) begin
         drive_only(3'b100, 3'b100);
         drive_only(3'b110, 3'b100);
         drive_only(3'b001, 3'b100);
         drive_only(3'b010, 3'b100);
      end
      drive_only(3'b100, 3'b100);
      step_id++;
      chk("sat_phases_done", 32'(phases_done), 32'd255);
      chk("sat_err_code",    32'(err_code),    32'd4);
      chk("sat_err_light",   32'(err_light),   32'd1);
      chk("sat_err_time",    32'(err_time),    32'd16);
      chk("sat_cycle_count", 32'(cycle_count), 32'd1041);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/twotrafficlights_monitor.md
Name: twotrafficlights_monitor

Overview:
- Passive checker on the output side of the two-light controller. Samples lightsA/lightsB every clock and checks each light's encoding and its sequence.
- Checks the cross-light safety rule and maximum dwell per aspect.
- Reports the first violation as a sticky flag with code, light and timestamp. Also counts completed light cycles.
- Sits in benches and FPGA builds beside the controller. Drives nothing back into it.

Parameters:
MAX_DWELL, 16, max consecutive cycles one light may hold the same aspect; one more cycle is a STUCK violation
CNT_W, 16, width of cycle timestamp counter
PH_W, 8, width of completed-cycle counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
lightsA  input  3  light A, {red,amber,green}
lightsB  input  3  light B, same encoding
err  output  1  sticky: a violation has been captured
err_code  output  3  code of first violation (package enum)
err_light  output  1  0 = light A, 1 = light B (0 for CONFLICT)
err_time  output  CNT_W  cycle_count value when the violation was sampled
cycle_count  output  CNT_W  samples since reset, saturating at all-ones
phases_done  output  PH_W  completed red→red cycles, A plus B, saturating

Behaviour:
- Reset is async, active-high. While rst=1 all outputs are 0, err_code=NONE(000), and the checkers return to UNSEEN. No checking occurs while rst=1.
- Legal aspects: RED=100, RED_AMB=110, GREEN=001, AMBER=010.
- Legal successor of each aspect is itself or the next in the cycle RED→RED_AMB→GREEN→AMBER→RED.
- Per-light checker states: UNSEEN, RED, RED_AMB, GREEN, AMBER. Each checker also holds a dwell counter of width clog2(MAX_DWELL+1).
- UNSEEN (first sample after reset):
  - Legal sample: load its aspect, dwell=1. No transition check.
  - Illegal sample: ILLEGAL (001).
- Each later sample:
  - Not one of the 4 codes → ILLEGAL (001).
  - Legal code but not a legal successor → BAD_TRANS (011).
  - Same aspect: dwell++ (saturating). dwell reaching MAX_DWELL+1 → STUCK (100).
  - Legal change: dwell=1.
  - AMBER→RED transition: completion pulse.
- After an ILLEGAL sample, the checker state and dwell are unchanged.
- Safety: any cycle where neither light is exactly RED → CONFLICT (010). Checked from the first sample.
- Capture:
  - When err=0 and at least one violation is present, the registers update on that edge: err=1, err_code, err_light, err_time=cycle_count before increment.
  - Violation visible on outputs one cycle after the offending sample.
  - After capture, err* are frozen until reset. Checking continues internally.
- Simultaneous violations, priority: ILLEGAL > CONFLICT > BAD_TRANS > STUCK. Within one code, A beats B.
- cycle_count increments every non-reset edge and saturates at 2^CNT_W−1.
- phases_done adds 0, 1 or 2 per edge (both lights completing together adds 2). It saturates at 2^PH_W−1 and never wraps.
- rst asserted mid-operation clears everything immediately. The first sample after release is treated as UNSEEN.

Decomposition:
- Package twotrafficlights_pkg:
  - light_t encoding constants RED, RED_AMB, GREEN, AMBER.
  - err_code_t enum NONE=0, ILLEGAL=1, CONFLICT=2, BAD_TRANS=3, STUCK=4.
  - Function is_legal(light_t).
  - Function next_aspect(light_t).
- Sub-module light_seq_checker, instantiated once for A and once for B.
  - Inputs: clk, rst, light.
  - Outputs: is_red, illegal, bad_trans, stuck, completed.
- Top level holds conflict logic, priority encoding, capture registers and counters.

Test Plan:
- Reset, then A runs 100→110→001→010→100 with 3 cycles per aspect while B=100 → err=0, phases_done=1 after A returns to RED.
- A=001, B=001 on sample 5 after reset → next cycle err=1, err_code=010, err_light=0, err_time=4.
- A jumps 100→001, B=100, at sample 7 → err_code=011, err_light=0, err_time=6. A later CONFLICT does not change err_code.
- B=111 while A also takes BAD_TRANS in the same cycle → err_code=001, err_light=1 (priority check).
- A held at 100 for 17 samples with MAX_DWELL=16 → err_code=100, err_light=0, err_time=16.
- rst pulsed mid-run after an error, then legal traffic → all outputs 0 during reset. Afterwards err=0, cycle_count restarts from 0, and the first sample is not transition-checked.
